// File: rtl/controller_in_capture_pkg.sv
// controller_in_capture_pkg
//   Shared definitions for the controller input capture buffer.
//   - cic_ch_w      : width of a channel index for a given channel count
//   - cic_entry_w   : packed width of one FIFO entry {ch, ts, data}
//   - CIC_ENTRY_T   : parametrised packed entry struct (a package cannot
//                     hold a parametrised typedef, so it is a macro)
//   - CIC_PACK      : build an entry from its fields
//   - CIC_UNPACK    : split an entry back into its fields
`ifndef CONTROLLER_IN_CAPTURE_PKG_SV
`define CONTROLLER_IN_CAPTURE_PKG_SV

`define CIC_ENTRY_T(CHW, TSW, DW) struct packed { logic [(CHW)-1:0] ch; logic [(TSW)-1:0] ts; logic [(DW)-1:0] data; }
`define CIC_PACK(CH, TS, DATA) {CH, TS, DATA}
`define CIC_UNPACK(E, CH, TS, DATA) {CH, TS, DATA} = E

package controller_in_capture_pkg;

   function automatic int cic_ch_w(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

   function automatic int cic_entry_w(input int num_ch, input int ts_w, input int data_w);
      return cic_ch_w(num_ch) + ts_w + data_w;
   endfunction

endpackage

`endif

// File: rtl/controller_in_capture_fifo.sv
// controller_in_capture_fifo
//   Generic synchronous FIFO, first-word-fall-through read (rd_data is the
//   memory head, combinational).
//   Ports:
//     clock, reset (sync, active-low)
//     wr_en, wr_data : push (ignored when full unless a read happens too)
//     rd_en, rd_data : pop / head entry (ignored when empty)
//     empty, full    : occupancy flags
//     level          : current occupancy, 0..DEPTH
module controller_in_capture_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/controller_in_capture_buffer.sv
// controller_in_capture_buffer
//   Multi-channel capture buffer: per-channel change filter and one-entry
//   skid, round-robin arbitration into a shared FIFO, timestamping and
//   saturating loss accounting.
//   Ports:
//     clock, reset              : rising-edge clock, sync active-low reset
//     ch_valid[NUM_CH]          : per-channel sample strobe
//     ch_data[NUM_CH*DATA_WIDTH]: channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//     change_only               : accept only data differing from last accepted
//     clear_drop                : clear drop_count / overflow
//     out_valid/out_ready       : head-of-FIFO stream handshake
//     out_ch, out_ts, out_data  : head entry fields
//     level                     : FIFO occupancy
//     drop_count, overflow      : saturating loss count, sticky loss flag
module controller_in_capture_buffer
   import controller_in_capture_pkg::*;
#(
   parameter int  NUM_CH     = 4,
   parameter int  DATA_WIDTH = 16,
   parameter int  DEPTH      = 16,
   parameter int  TS_WIDTH   = 16,
   parameter int  DROP_WIDTH = 8,
   localparam int CH_W       = cic_ch_w(NUM_CH)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            ch_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
   input  logic                         change_only,
   input  logic                         clear_drop,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CH_W-1:0]              out_ch,
   output logic [TS_WIDTH-1:0]          out_ts,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [$clog2(DEPTH):0]       level,
   output logic [DROP_WIDTH-1:0]        drop_count,
   output logic                         overflow
);

   typedef `CIC_ENTRY_T(CH_W, TS_WIDTH, DATA_WIDTH) entry_t;

   function automatic logic [DROP_WIDTH-1:0] sat_add(input logic [DROP_WIDTH-1:0] base,
                                                     input int inc);
      longint sum;
      sum = longint'(base) + longint'(inc);
      if (sum > longint'({DROP_WIDTH{1'b1}})) return '1;
      return DROP_WIDTH'(sum);
   endfunction

   logic [TS_WIDTH-1:0]   ts;
   logic [CH_W-1:0]       rr_ptr;
   logic [NUM_CH-1:0]     seen;
   logic [DATA_WIDTH-1:0] last_data [NUM_CH];

   logic [NUM_CH-1:0]     vld_p0;
   logic [DATA_WIDTH-1:0] skid_data_p0 [NUM_CH];
   logic [TS_WIDTH-1:0]   skid_ts_p0 [NUM_CH];

   logic [NUM_CH-1:0]     accept;
   logic [NUM_CH-1:0]     load;
   logic [NUM_CH-1:0]     gnt_oh;
   logic [CH_W-1:0]       gnt_idx;
   logic                  gnt_any;
   int                    n_drop;

   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_rd;
   logic                  fifo_can_wr;
   entry_t                wr_entry;
   entry_t                rd_entry;

   assign out_valid   = !fifo_empty;
   assign fifo_rd     = out_valid && out_ready;
   assign fifo_can_wr = !fifo_full || fifo_rd;

   // Input stage: change filter. last_data/seen track every accepted sample
   // regardless of mode, so toggling change_only only affects later decisions.
   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         accept[i] = ch_valid[i] &&
                     (!change_only || !seen[i] ||
                      (ch_data[i*DATA_WIDTH +: DATA_WIDTH] != last_data[i]));
      end
   end

   // Arbitration stage (p0 -> FIFO): first full skid at or after rr_ptr.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      if (fifo_can_wr) begin
         for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (!gnt_any && vld_p0[i] && (((int'(rr_ptr) + k) % NUM_CH) == i)) begin
                  gnt_any   = 1'b1;
                  gnt_idx   = CH_W'(i);
                  gnt_oh[i] = 1'b1;
               end
            end
         end
      end
   end

   // A skid being granted this cycle frees up in time to take a new sample.
   always_comb begin
      load   = '0;
      n_drop = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (accept[i]) begin
            if (!vld_p0[i] || gnt_oh[i]) load[i] = 1'b1;
            else                         n_drop = n_drop + 1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ts         <= '0;
         rr_ptr     <= '0;
         vld_p0     <= '0;
         seen       <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) last_data[i] <= '0;
      end else begin
         ts <= ts + TS_WIDTH'(1);
         if (gnt_any)
            rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
         for (int i = 0; i < NUM_CH; i++) begin
            if (load[i])        vld_p0[i] <= 1'b1;
            else if (gnt_oh[i]) vld_p0[i] <= 1'b0;
            if (accept[i]) begin
               seen[i]      <= 1'b1;
               last_data[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         // clear_drop wins over the old count but not over this cycle's drops.
         drop_count <= sat_add(clear_drop ? '0 : drop_count, n_drop);
         overflow   <= (n_drop != 0) || (overflow && !clear_drop);
      end
   end

   // Skid stage p0: payload registers, qualified by vld_p0.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (load[i]) begin
            skid_data_p0[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            skid_ts_p0[i]   <= ts;
         end
      end
   end

   assign wr_entry = `CIC_PACK(gnt_idx, skid_ts_p0[gnt_idx], skid_data_p0[gnt_idx]);

   // FIFO stage: shared queue toward the consumer.
   controller_in_capture_fifo #(
      .WIDTH (cic_entry_w(NUM_CH, TS_WIDTH, DATA_WIDTH)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (gnt_any),
      .wr_data (wr_entry),
      .rd_en   (fifo_rd),
      .rd_data (rd_entry),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (level)
   );

   assign `CIC_UNPACK(rd_entry, out_ch, out_ts, out_data);

endmodule

// File: tb/tb_controller_in_capture_buffer.sv
// tb_controller_in_capture_buffer
//   Directed bench for controller_in_capture_buffer (NUM_CH=4, DEPTH=16).
//   A second instance with DROP_WIDTH=2 shares all inputs to exercise
//   drop-counter saturation.
module tb_controller_in_capture_buffer;

   logic        clock;
   logic        reset;
   logic [3:0]  ch_valid;
   logic [63:0] ch_data;
   logic        change_only;
   logic        clear_drop;
   logic        out_ready;

   logic        out_valid;
   logic [1:0]  out_ch;
   logic [15:0] out_ts;
   logic [15:0] out_data;
   logic [4:0]  level;
   logic [7:0]  drop_count;
   logic        overflow;

   logic        s_out_valid;
   logic [1:0]  s_out_ch;
   logic [15:0] s_out_ts;
   logic [15:0] s_out_data;
   logic [4:0]  s_level;
   logic [1:0]  s_drop_count;
   logic        s_overflow;

   int checks;
   int passes;
   int cyc;

   logic [1:0]  cap_ch[$];
   logic [15:0] cap_data[$];
   logic [15:0] cap_ts[$];
   int          cap_cyc[$];

   controller_in_capture_buffer #(
      .NUM_CH(4), .DATA_WIDTH(16), .DEPTH(16), .TS_WIDTH(16), .DROP_WIDTH(8)
   ) dut (
      .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
      .change_only(change_only), .clear_drop(clear_drop),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_ts(out_ts), .out_data(out_data), .level(level),
      .drop_count(drop_count), .overflow(overflow)
   );

   controller_in_capture_buffer #(
      .NUM_CH(4), .DATA_WIDTH(16), .DEPTH(16), .TS_WIDTH(16), .DROP_WIDTH(2)
   ) dut_sat (
      .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
      .change_only(change_only), .clear_drop(clear_drop),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_ch(s_out_ch),
      .out_ts(s_out_ts), .out_data(s_out_data), .level(s_level),
      .drop_count(s_drop_count), .overflow(s_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Record every handshake of the main instance.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready) begin
         cap_ch.push_back(out_ch);
         cap_data.push_back(out_data);
         cap_ts.push_back(out_ts);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [15:0] v);
      ch_data[i*16 +: 16] = v;
   endtask

   task automatic clear_cap();
      cap_ch.delete();
      cap_data.delete();
      cap_ts.delete();
      cap_cyc.delete();
   endtask

   // Leaves the bench in cycle 0 after release (ts = 0).
   task automatic do_reset();
      reset       = 1'b0;
      ch_valid    = '0;
      ch_data     = '0;
      change_only = 1'b0;
      clear_drop  = 1'b0;
      out_ready   = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      clear_cap();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
      checks++; if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level); else passes++;
      checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop_count: got %0d want 0", drop_count); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passes++;
   endtask

   task automatic test_single_pulse();
      do_reset();
      repeat (5) tick();
      ch_valid = 4'b0100;
      set_ch(2, 16'h00A5);
      tick();
      ch_valid = '0;
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) $display("FAIL pulse_early_valid: got %b want 0", out_valid); else passes++;
      tick();
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) $display("FAIL pulse_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_ch !== 2'd2) $display("FAIL pulse_ch: got %0d want 2", out_ch); else passes++;
      checks++; if (out_data !== 16'h00A5) $display("FAIL pulse_data: got %h want 00a5", out_data); else passes++;
      checks++; if (out_ts !== 16'd5) $display("FAIL pulse_ts: got %0d want 5", out_ts); else passes++;
   endtask

   task automatic test_burst();
      int exp_ch [9];
      int exp_dt [9];
      exp_ch = '{0, 1, 2, 3, 1, 2, 3, 0, 1};
      exp_dt = '{1, 2, 3, 4, 16'h0B0B, 7, 8, 5, 6};
      do_reset();
      ch_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_ch(i, 16'(i + 1));
      tick();
      ch_valid = '0;
      repeat (8) tick();
      checks++; if (cap_ch.size() !== 4) $display("FAIL burst1_count: got %0d want 4", cap_ch.size()); else passes++;
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (cap_cyc[k] !== cap_cyc[0] + k) $display("FAIL burst1_consecutive[%0d]: got cycle %0d want %0d", k, cap_cyc[k], cap_cyc[0] + k);
         else passes++;
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cap_ts[k] !== 16'd0) $display("FAIL burst1_ts[%0d]: got %0d want 0", k, cap_ts[k]); else passes++;
      end
      // single ch1 sample moves rr_ptr to 2, then a second full burst
      ch_valid = 4'b0010;
      set_ch(1, 16'h0B0B);
      tick();
      ch_valid = '0;
      repeat (4) tick();
      ch_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_ch(i, 16'(i + 5));
      tick();
      ch_valid = '0;
      repeat (8) tick();
      checks++; if (cap_ch.size() !== 9) $display("FAIL burst_total_count: got %0d want 9", cap_ch.size()); else passes++;
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (cap_ch[k] !== 2'(exp_ch[k]) || cap_data[k] !== 16'(exp_dt[k]))
            $display("FAIL burst_entry[%0d]: got ch %0d data %h want ch %0d data %h", k, cap_ch[k], cap_data[k], exp_ch[k], exp_dt[k]);
         else passes++;
      end
      checks++; if (drop_count !== 8'd0) $display("FAIL burst_drop_count: got %0d want 0", drop_count); else passes++;
   endtask

   task automatic test_change_only();
      int seq [5];
      int exp_dt [4];
      seq    = '{3, 3, 7, 7, 3};
      exp_dt = '{3, 7, 3, 3};
      do_reset();
      change_only = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ch_valid = 4'b0001;
         set_ch(0, 16'(seq[k]));
         tick();
      end
      ch_valid = '0;
      repeat (6) tick();
      checks++; if (cap_data.size() !== 3) $display("FAIL change_count: got %0d want 3", cap_data.size()); else passes++;
      // repeat of 3 is accepted with filtering off, then rejected with it back on
      change_only = 1'b0;
      ch_valid = 4'b0001;
      set_ch(0, 16'd3);
      tick();
      ch_valid = '0;
      tick();
      change_only = 1'b1;
      ch_valid = 4'b0001;
      tick();
      ch_valid = '0;
      repeat (5) tick();
      checks++; if (cap_data.size() !== 4) $display("FAIL change_toggle_count: got %0d want 4", cap_data.size()); else passes++;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cap_data[k] !== 16'(exp_dt[k])) $display("FAIL change_data[%0d]: got %0d want %0d", k, cap_data[k], exp_dt[k]);
         else passes++;
      end
      checks++; if (drop_count !== 8'd0) $display("FAIL change_drop_count: got %0d want 0", drop_count); else passes++;
      change_only = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         ch_valid = 4'b0010;
         set_ch(1, 16'h0100 + 16'(k));
         tick();
      end
      ch_valid = '0;
      @(negedge clock);
      checks++; if (level !== 5'd16) $display("FAIL ovf_level: got %0d want 16", level); else passes++;
      checks++; if (drop_count !== 8'd3) $display("FAIL ovf_drop_count: got %0d want 3", drop_count); else passes++;
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_overflow: got %b want 1", overflow); else passes++;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0100) $display("FAIL ovf_head: got valid %b data %h want 1 0100", out_valid, out_data); else passes++;
      tick();
      clear_drop = 1'b1;
      tick();
      clear_drop = 1'b0;
      @(negedge clock);
      checks++; if (drop_count !== 8'd0) $display("FAIL ovf_clear_count: got %0d want 0", drop_count); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear_flag: got %b want 0", overflow); else passes++;
      checks++; if (level !== 5'd16 || out_data !== 16'h0100) $display("FAIL ovf_hold: got level %0d data %h want 16 0100", level, out_data); else passes++;
      clear_cap();
      out_ready = 1'b1;
      repeat (25) tick();
      checks++; if (cap_data.size() !== 17) $display("FAIL drain_count: got %0d want 17", cap_data.size()); else passes++;
      for (int k = 0; k < 17; k++) begin
         checks++;
         if (cap_data[k] !== 16'h0100 + 16'(k) || cap_ch[k] !== 2'd1)
            $display("FAIL drain_entry[%0d]: got ch %0d data %h want ch 1 data %h", k, cap_ch[k], cap_data[k], 16'h0100 + 16'(k));
         else passes++;
      end
      @(negedge clock);
      checks++; if (level !== 5'd0 || out_valid !== 1'b0) $display("FAIL drain_empty: got level %0d valid %b want 0 0", level, out_valid); else passes++;
   endtask

   task automatic test_saturation_and_reset();
      do_reset();
      out_ready = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         ch_valid = 4'hF;
         for (int i = 0; i < 4; i++) set_ch(i, 16'(c * 16 + i));
         tick();
      end
      ch_valid   = 4'hF;
      clear_drop = 1'b1;
      for (int i = 0; i < 4; i++) set_ch(i, 16'(64 + i));
      @(negedge clock);
      checks++; if (drop_count !== 8'd6) $display("FAIL sat_wide_count: got %0d want 6", drop_count); else passes++;
      checks++; if (s_drop_count !== 2'd3) $display("FAIL sat_narrow_count: got %0d want 3", s_drop_count); else passes++;
      checks++; if (s_overflow !== 1'b1) $display("FAIL sat_narrow_overflow: got %b want 1", s_overflow); else passes++;
      tick();
      ch_valid   = '0;
      clear_drop = 1'b0;
      @(negedge clock);
      checks++; if (drop_count !== 8'd3) $display("FAIL clear_with_drop_count: got %0d want 3", drop_count); else passes++;
      checks++; if (overflow !== 1'b1) $display("FAIL clear_with_drop_flag: got %b want 1", overflow); else passes++;
      checks++; if (level !== 5'd3) $display("FAIL sat_level: got %0d want 3", level); else passes++;
      tick();
      // reset mid-burst, with samples offered during reset
      ch_valid = 4'hF;
      reset    = 1'b0;
      tick();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", out_valid); else passes++;
      checks++; if (level !== 5'd0) $display("FAIL midreset_level: got %0d want 0", level); else passes++;
      checks++; if (drop_count !== 8'd0) $display("FAIL midreset_drop: got %0d want 0", drop_count); else passes++;
      tick();
      reset     = 1'b1;
      ch_valid  = '0;
      out_ready = 1'b1;
      clear_cap();
      repeat (4) tick();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0 || level !== 5'd0) $display("FAIL postreset_empty: got valid %b level %0d want 0 0", out_valid, level); else passes++;
      checks++; if (cap_data.size() !== 0) $display("FAIL postreset_stale: got %0d entries want 0", cap_data.size()); else passes++;
      tick();
      ch_valid = 4'b1000;
      set_ch(3, 16'h0077);
      tick();
      ch_valid = '0;
      tick();
      @(negedge clock);
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 16'h0077)
         $display("FAIL postreset_new: got valid %b ch %0d data %h want 1 3 0077", out_valid, out_ch, out_data);
      else passes++;
      repeat (3) tick();
      checks++; if (cap_data.size() !== 1) $display("FAIL postreset_count: got %0d want 1", cap_data.size()); else passes++;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_single_pulse();
      test_burst();
      test_change_only();
      test_overflow();
      test_saturation_and_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/controller_in_capture_buffer.md
# controller_in_capture_buffer

Parametrised multi-channel capture buffer on the HDL side of the controller input interface. It samples up to NUM_CH independent controller input channels, stamps each accepted sample with a free-running cycle timestamp, arbitrates round-robin into one shared FIFO, and presents the entries on a ready/valid stream toward the HVL transactor or monitor. It adds three things the single-channel interface path does not have: per-channel skid buffering, a change-only filtering mode, and loss accounting.

## Interface
- NUM_CH, 4: number of input channels (1..16)
- DATA_WIDTH, 16: payload width per channel
- DEPTH, 16: FIFO entries; power of two, at least 2
- TS_WIDTH, 16: timestamp width
- DROP_WIDTH, 8: drop counter width
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-low
- ch_valid  in  NUM_CH  sample strobe per channel
- ch_data  in  NUM_CH*DATA_WIDTH  channel i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- change_only  in  1  1: accept a sample only if its data differs from that channel's last accepted data
- clear_drop  in  1  clears drop_count and overflow
- out_valid  out  1  FIFO head valid (FIFO not empty)
- out_ready  in  1  consumer accepts head
- out_ch  out  CH_W  channel index of head entry; CH_W = max(1, $clog2(NUM_CH))
- out_ts  out  TS_WIDTH  timestamp of head entry
- out_data  out  DATA_WIDTH  payload of head entry
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_count  out  DROP_WIDTH  saturating count of lost samples
- overflow  out  1  sticky; set by any drop

## Operation
- Timestamp counter ts: increments every cycle and wraps modulo 2^TS_WIDTH. A sample is stamped with the ts value of the cycle in which ch_valid is high.
- Accept rule for channel i: ch_valid[i] is high, and either change_only=0, or seen[i]=0, or ch_data_i differs from last[i]. On accept, last[i] takes the data and seen[i] is set to 1.
- Each channel has a one-entry skid register {data, ts, full}.
  - An accepted sample loads the skid if the skid is empty, or if it is being granted this cycle.
  - Otherwise the sample is dropped.
- Arbiter:
  - Among full skids, grant the first index at or after rr_ptr, searching with wrap.
  - A grant occurs only when the FIFO can be written, i.e. it is not full, or it is full and being read this cycle.
  - After a grant, rr_ptr becomes (grant+1) mod NUM_CH.
  - At most one grant per cycle.
- FIFO write data is {grant index, skid ts, skid data}. Read happens on out_valid & out_ready. Simultaneous read and write keeps level unchanged.
- Drops:
  - drop_count increments by the number of channels dropping in a cycle and saturates at all-ones.
  - overflow is set on any drop.
  - If clear_drop and a drop occur in the same cycle, the result is drop_count equal to that cycle's drops and overflow=1.
- Toggling change_only affects only the accept decisions that follow it. last[] and seen[] continue to be tracked in both modes.

## Timing
- Reset values: out_valid=0, level=0, drop_count=0, overflow=0. Reset also clears ts=0, rr_ptr=0, all skids empty, seen[]=0, last[]=0, and the FIFO pointers.
- out_ch, out_ts and out_data show the FIFO head and are don't-care while out_valid=0.
- Reset asserted mid-operation discards all skid and FIFO contents on the next edge. Inputs are ignored while reset=0.
- Latency with an empty FIFO and no contention:
  - ch_valid at cycle t loads the skid at the t edge.
  - The grant writes the FIFO at the t+1 edge.
  - out_valid is high in cycle t+2.
- Full FIFO with out_ready=0: out_valid stays high and the head is stable, with no grants. Skids hold, and new samples on channels with full skids drop.
- A channel may sustain one sample per cycle with no loss only if it is granted every cycle.

## Structure
- Shared package controller_in_capture_pkg holds:
  - the function computing CH_W from NUM_CH
  - a parametrised entry typedef {ch, ts, data}
  - packing and unpacking macros alongside the existing controller_in typedef and macro files
- Sub-module controller_in_capture_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH.
  - Pointers are $clog2(DEPTH)+1 bits wide.
  - Ports: wr_en, wr_data, rd_en, rd_data, empty, full, level.
  - Read data comes from the memory head combinationally.
- Top level holds the skids, the change filter, the round-robin arbiter, ts and the drop logic.

## Test plan
- NUM_CH=4, DEPTH=16, out_ready=1: single pulse ch_valid=4'b0100, data 16'h00A5, in cycle 5 after reset release → out_valid in cycle 7 with out_ch=2, out_data=16'h00A5, out_ts=5.
- All 4 channels valid in one cycle, data 1..4, out_ready=1 → four entries emitted in channel order 0,1,2,3 on consecutive cycles; drop_count=0. Repeat the burst → order rotates correctly from rr_ptr.
- change_only=1: channel 0 gets 3, 3, 7, 7, 3 on consecutive valids → exactly three entries with data 3, 7, 3; drop_count=0.
- out_ready=0 and 20 single-channel samples on channel 1 → level=16, one sample held in the skid, 3 drops (drop_count=3, overflow=1). Then clear_drop → both return to 0. Then out_ready=1 → 17 entries drained in order.
- DROP_WIDTH=2 with 6 forced drops → drop_count saturates at 3. Assert reset mid-burst → next cycle out_valid=0, level=0, and the FIFO stays empty until new samples arrive.
